// File: rtl/io_n_bidir_reg.sv
// io_n_bidir_reg: N-channel bidirectional IO with optional output/tristate registers, input sync and sticky edge flags
module io_n_bidir_reg #(
   parameter int NUM_CH      = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   UserCLK,
   input  logic                   UserRSTn,
   input  logic [NUM_CH-1:0]      I,
   input  logic [NUM_CH-1:0]      T,
   input  logic [NUM_CH-1:0]      O_top,
   output logic [NUM_CH-1:0]      I_top,
   output logic [NUM_CH-1:0]      T_top,
   output logic [NUM_CH-1:0]      O,
   output logic [NUM_CH-1:0]      Q,
   output logic [NUM_CH-1:0]      EDGE,
   input  logic [NUM_CH-1:0]      EDGE_CLR,
   input  logic [NUM_CH*4-1:0]    ConfigBits
);
   localparam int CFG_W = 4;
   localparam int WU_W = $clog2(SYNC_STAGES + 2);
   localparam logic [WU_W-1:0] WU_MAX = WU_W'(SYNC_STAGES + 1);
   if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
      $error("NUM_CH must be in 1..32");
   end
   if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("SYNC_STAGES must be in 1..4");
   end
   logic [NUM_CH*CFG_W-1:0]             cfg;
   logic [NUM_CH-1:0]                   i_reg, t_reg, prev, hit;
   logic [SYNC_STAGES-1:0][NUM_CH-1:0]  sync;
   logic [WU_W-1:0]                     wu;
   logic                                warm;
   // Config is sampled so mode changes land on a clock edge; it is static tile memory, so no reset is needed.
   always_ff @(posedge UserCLK)
      cfg <= ConfigBits;
   always_ff @(posedge UserCLK or negedge UserRSTn)
      if (!UserRSTn) begin
         i_reg <= '0;
         t_reg <= '1;
         sync  <= '0;
         prev  <= '0;
         wu    <= '0;
         EDGE  <= '0;
      end else begin
         i_reg   <= I;
         t_reg   <= T;
         sync[0] <= O_top;
         for (int s = 1; s < SYNC_STAGES; s++)
            sync[s] <= sync[s-1];
         prev <= Q;
         wu   <= warm ? wu : wu + WU_W'(1);
         EDGE <= (EDGE & ~EDGE_CLR) | hit;
      end
   assign warm = wu == WU_MAX;
   assign Q    = sync[SYNC_STAGES-1];
   assign O    = O_top;
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [1:0] mode;
      assign mode     = cfg[CFG_W*c+2 +: 2];
      assign hit[c]   = warm & ((mode[0] & Q[c] & ~prev[c]) | (mode[1] & ~Q[c] & prev[c]));
      assign I_top[c] = cfg[CFG_W*c]   ? i_reg[c] : I[c];
      assign T_top[c] = cfg[CFG_W*c+1] ? t_reg[c] : T[c];
   end
endmodule

// File: tb/tb_io_n_bidir_reg.sv
// tb_io_n_bidir_reg: two instances (2- and 4-stage sync) checked against a sample-history model plus literal expectations
module tb_io_n_bidir_reg;
   logic clk = 0, rst_n = 0;
   logic [1:0] din = 2'b11, tin = 2'b00, otop = 2'b00, clr = 2'b00;
   logic [7:0] cfg = {4'b1000, 4'b0111};
   logic [1:0] i_top_a, t_top_a, o_a, q_a, edge_a;
   logic [1:0] i_top_b, t_top_b, o_b, q_b, edge_b;
   int checks = 0, errors = 0;
   bit chk_en = 0;
   io_n_bidir_reg #(.NUM_CH(2), .SYNC_STAGES(2)) dut_a (
      .UserCLK(clk), .UserRSTn(rst_n), .I(din), .T(tin), .O_top(otop),
      .I_top(i_top_a), .T_top(t_top_a), .O(o_a), .Q(q_a), .EDGE(edge_a),
      .EDGE_CLR(clr), .ConfigBits(cfg));
   io_n_bidir_reg #(.NUM_CH(2), .SYNC_STAGES(4)) dut_b (
      .UserCLK(clk), .UserRSTn(rst_n), .I(din), .T(tin), .O_top(otop),
      .I_top(i_top_b), .T_top(t_top_b), .O(o_b), .Q(q_b), .EDGE(edge_b),
      .EDGE_CLR(clr), .ConfigBits(cfg));
   always #5 clk = ~clk;
   // Model: smp[k] is the pad value sampled at the k-th edge since reset release; Q after n edges is smp[n-s+1].
   bit [1:0] smp [0:1023];
   int n = 0;
   bit [1:0] m_edge_a = 0, m_edge_b = 0, m_ir = 0, m_tr = 2'b11;
   bit [7:0] m_cfg = 0;
   function automatic bit [1:0] qv(int m, int s);
      return (m - s + 1 >= 1) ? smp[m-s+1] : 2'b00;
   endfunction
   function automatic bit [1:0] det(int s);
      bit [1:0] q, p, r;
      q = qv(n, s);
      p = qv(n - 1, s);
      for (int c = 0; c < 2; c++)
         r[c] = (n >= s + 1) && ((m_cfg[4*c+2] && q[c] && !p[c]) || (m_cfg[4*c+3] && !q[c] && p[c]));
      return r;
   endfunction
   function automatic bit [1:0] sel(bit [1:0] r, bit [1:0] x, int b);
      bit [1:0] y;
      for (int c = 0; c < 2; c++)
         y[c] = m_cfg[4*c+b] ? r[c] : x[c];
      return y;
   endfunction
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         n <= 0;
         m_edge_a <= 0;
         m_edge_b <= 0;
         m_ir <= 0;
         m_tr <= 2'b11;
      end else begin
         smp[n+1] <= otop;
         m_edge_a <= (m_edge_a & ~clr) | det(2);
         m_edge_b <= (m_edge_b & ~clr) | det(4);
         m_ir <= din;
         m_tr <= tin;
         n <= n + 1;
      end
   always @(posedge clk) m_cfg <= cfg;
   task automatic chk(string nm, logic [1:0] act, logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk)
      if (chk_en) begin
         chk("o_a", o_a, otop);
         chk("i_top_a", i_top_a, sel(m_ir, din, 0));
         chk("t_top_a", t_top_a, sel(m_tr, tin, 1));
         chk("q_a", q_a, qv(n, 2));
         chk("edge_a", edge_a, m_edge_a);
         chk("o_b", o_b, otop);
         chk("i_top_b", i_top_b, sel(m_ir, din, 0));
         chk("t_top_b", t_top_b, sel(m_tr, tin, 1));
         chk("q_b", q_b, qv(n, 4));
         chk("edge_b", edge_b, m_edge_b);
      end
   task automatic tick(int k = 1);
      repeat (k) begin
         @(posedge clk);
         #2;
      end
   endtask
   initial begin
      tick();
      chk_en = 1;
      tick(2);
      chk("rst_i_top", i_top_a, 2'b10);
      chk("rst_t_top", t_top_a, 2'b01);
      chk("rst_q", q_a, 2'b00);
      chk("rst_edge", edge_a, 2'b00);
      rst_n = 1;
      tick();
      chk("reg_i_top", i_top_a, 2'b11);
      chk("reg_t_top", t_top_a, 2'b00);
      tick(4);
      otop = 2'b01;
      tick();
      chk("rise_q_early", q_a, 2'b00);
      tick();
      chk("rise_q", q_a, 2'b01);
      chk("rise_edge_early", edge_a, 2'b00);
      tick();
      chk("rise_edge", edge_a, 2'b01);
      clr = 2'b01;
      tick();
      clr = 2'b00;
      chk("clr_edge", edge_a, 2'b00);
      cfg[3:0] = 4'b1111;
      otop = 2'b00;
      tick(2);
      clr = 2'b01;
      tick();
      clr = 2'b00;
      chk("set_beats_clr", edge_a, 2'b01);
      cfg[3:0] = 4'b0011;
      tick(3);
      chk("mode0_holds", edge_a, 2'b01);
      clr = 2'b01;
      tick();
      clr = 2'b00;
      chk("clr_again", edge_a, 2'b00);
      cfg[3:0] = 4'b0010;
      tick(2);
      cfg[3:0] = 4'b0011;
      #1;
      chk("outreg_sw_pre", i_top_a, 2'b11);
      tick();
      chk("outreg_sw_post", i_top_a, 2'b11);
      cfg[3:0] = 4'b0111;
      otop = 2'b01;
      tick(3);
      chk("pre_rst_edge", edge_a, 2'b01);
      rst_n = 0;
      #1;
      chk("async_edge_a", edge_a, 2'b00);
      chk("async_q_a", q_a, 2'b00);
      chk("async_q_b", q_b, 2'b00);
      chk("async_i_top", i_top_a, 2'b10);
      chk("async_t_top", t_top_a, 2'b01);
      tick(2);
      rst_n = 1;
      tick();
      chk("warm_q1", q_a, 2'b00);
      tick();
      chk("warm_q2", q_a, 2'b01);
      chk("s4_q2", q_b, 2'b00);
      tick();
      chk("s4_q3", q_b, 2'b00);
      tick();
      chk("s4_q4", q_b, 2'b01);
      chk("warm_edge_a", edge_a, 2'b00);
      tick(3);
      chk("warm_edge_a2", edge_a, 2'b00);
      chk("warm_edge_b", edge_b, 2'b00);
      cfg[3:0] = 4'b1111;
      otop = 2'b00;
      tick(3);
      chk("fall_edge", edge_a, 2'b01);
      otop = 2'b10;
      tick(6);
      otop = 2'b00;
      tick(3);
      chk("ch1_fall", edge_a, 2'b11);
      repeat (40) begin
         din = 2'($urandom);
         tin = 2'($urandom);
         otop = 2'($urandom);
         clr = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         if ($urandom_range(0, 4) == 0) cfg = 8'($urandom);
         tick();
      end
      clr = 2'b00;
      tick(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
